// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, bit indices, cause codes and enums for csr_irq_ctrl
package csr_pkg;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MSI_BIT  = 3;
  localparam int MTI_BIT  = 7;
  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_EXT = 5'd16;
  typedef enum logic [1:0] {CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR} csr_op_e;
  typedef enum logic {RUN, REDIRECT} irq_state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder; pend={ext[N-1:0],mti,msi} in, valid and 5-bit cause code out
module irq_prio_enc
  import csr_pkg::*;
#(
  parameter int NUM_EXT_IRQ = 4
) (
  input  logic [NUM_EXT_IRQ+1:0] pend,
  output logic                   valid,
  output logic [4:0]             code
);
  logic [4:0] ext_code;
  always_comb begin
    ext_code = CAUSE_EXT;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--)
      if (pend[2+i]) ext_code = CAUSE_EXT + 5'(i);
  end
  assign valid = |pend;
  assign code  = pend[0] ? CAUSE_MSI : pend[1] ? CAUSE_MTI : ext_code;
endmodule

// File: rtl/csr_irq_ctrl.sv
// csr_irq_ctrl: M-mode CSRs + interrupt redirect; CSR op/addr/wdata in, rdata out, sw/timer/ext irqs in, trap/mret redirect pulses out
module csr_irq_ctrl
  import csr_pkg::*;
#(
  parameter int          NUM_EXT_IRQ = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [31:0]            pc_in,
  input  logic                   is_mret,
  input  logic [1:0]             csr_op,
  input  logic [11:0]            csr_addr,
  input  logic [31:0]            csr_wdata,
  output logic [31:0]            csr_rdata,
  input  logic                   sw_irq,
  input  logic                   timer_irq,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq,
  output logic                   trap_taken,
  output logic [31:0]            trap_pc,
  output logic                   epc_taken,
  output logic [31:0]            epc
);
  localparam logic [31:0] MIE_MASK = 32'h88 | (((32'd1 << NUM_EXT_IRQ) - 32'd1) << 16);
  irq_state_e state;
  csr_op_e op;
  logic mie_b, mpie_b, irq_valid, fire, mret_go, wr_en;
  logic [4:0] code;
  logic [31:0] mie_r, mtvec, mepc, mcause, mstatus, mip, wval, base;
  logic [NUM_EXT_IRQ+1:0] pend;
  assign op      = csr_op_e'(csr_op);
  assign mstatus = (32'(mpie_b) << MPIE_BIT) | (32'(mie_b) << MIE_BIT);
  assign mip     = (32'(ext_irq) << 16) | (32'(timer_irq) << MTI_BIT) | (32'(sw_irq) << MSI_BIT);
  assign pend    = {ext_irq & mie_r[16 +: NUM_EXT_IRQ], timer_irq & mie_r[MTI_BIT], sw_irq & mie_r[MSI_BIT]};
  irq_prio_enc #(.NUM_EXT_IRQ(NUM_EXT_IRQ)) u_enc (.pend(pend), .valid(irq_valid), .code(code));
  assign fire    = mie_b & irq_valid & instr_valid & ~is_mret & (state == RUN);
  assign mret_go = is_mret & (state == RUN);
  assign wr_en   = (op != CSR_NONE) & (state == RUN);
  assign base    = {mtvec[31:2], 2'b00};
  always_comb begin
    csr_rdata = csr_addr == A_MSTATUS ? mstatus :
                csr_addr == A_MIE     ? mie_r   :
                csr_addr == A_MTVEC   ? mtvec   :
                csr_addr == A_MEPC    ? mepc    :
                csr_addr == A_MCAUSE  ? mcause  :
                csr_addr == A_MIP     ? mip     : 32'h0;
    wval = op == CSR_WRITE ? csr_wdata :
           op == CSR_SET   ? csr_rdata | csr_wdata :
           op == CSR_CLEAR ? csr_rdata & ~csr_wdata : csr_rdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      mie_b      <= 1'b0;
      mpie_b     <= 1'b0;
      mie_r      <= '0;
      mtvec      <= RESET_MTVEC;
      mepc       <= '0;
      mcause     <= '0;
      trap_taken <= 1'b0;
      trap_pc    <= '0;
      epc_taken  <= 1'b0;
      epc        <= '0;
    end else if (state == REDIRECT) begin
      state      <= RUN;
      trap_taken <= 1'b0;
      epc_taken  <= 1'b0;
    end else begin
      trap_taken <= fire;
      epc_taken  <= mret_go;
      if (fire) begin
        mepc    <= pc_in & ~32'h3;
        mcause  <= {1'b1, 26'b0, code};
        mpie_b  <= mie_b;
        mie_b   <= 1'b0;
        trap_pc <= mtvec[0] ? base + (32'(code) << 2) : base;
        state   <= REDIRECT;
      end else if (mret_go) begin
        mie_b  <= mpie_b;
        mpie_b <= 1'b1;
        epc    <= mepc;
        state  <= REDIRECT;
      end else if (wr_en) begin
        if (csr_addr == A_MSTATUS) begin
          mie_b  <= wval[MIE_BIT];
          mpie_b <= wval[MPIE_BIT];
        end
        if (csr_addr == A_MIE) mie_r <= wval & MIE_MASK;
        // modes 2/3 are reserved: keep the previous mode bits
        if (csr_addr == A_MTVEC) mtvec <= {wval[31:2], wval[1] ? mtvec[1:0] : wval[1:0]};
        if (csr_addr == A_MEPC) mepc <= wval & ~32'h3;
        if (csr_addr == A_MCAUSE) mcause <= wval;
      end
    end
  end
endmodule

// File: tb/tb_csr_irq_ctrl.sv
// tb_csr_irq_ctrl: directed self-checking bench for csr_irq_ctrl
module tb_csr_irq_ctrl;
  logic clk = 0, rst = 1, instr_valid = 0, is_mret = 0, sw_irq = 0, timer_irq = 0;
  logic [31:0] pc_in = 0, csr_wdata = 0, csr_rdata, trap_pc, epc;
  logic [1:0] csr_op = 0;
  logic [11:0] csr_addr = 0;
  logic [3:0] ext_irq = 0;
  logic trap_taken, epc_taken;
  int n_chk = 0, n_fail = 0;
  csr_irq_ctrl #(.NUM_EXT_IRQ(4), .RESET_MTVEC(32'h100)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_in(pc_in), .is_mret(is_mret),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .sw_irq(sw_irq), .timer_irq(timer_irq), .ext_irq(ext_irq), .trap_taken(trap_taken),
    .trap_pc(trap_pc), .epc_taken(epc_taken), .epc(epc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] d);
    csr_op = op; csr_addr = addr; csr_wdata = d;
    tick();
    csr_op = 0;
  endtask
  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask
  task automatic do_mret(input logic [31:0] exp_epc);
    is_mret = 1;
    tick();
    is_mret = 0;
    chk("mret_pulse", {31'b0, epc_taken}, 1);
    chk("mret_epc", epc, exp_epc);
    tick();
    chk("mret_pulse_drop", {31'b0, epc_taken}, 0);
  endtask
  initial begin
    tick(); tick();
    chk("rst_trap_taken", {31'b0, trap_taken}, 0);
    chk("rst_epc_taken", {31'b0, epc_taken}, 0);
    chk("rst_trap_pc", trap_pc, 0);
    chk("rst_epc", epc, 0);
    rst = 0;
    rd("rst_mtvec", 12'h305, 32'h100);
    rd("rst_mstatus", 12'h300, 0);
    csr(1, 12'h304, 32'h80);
    csr(2, 12'h300, 32'h8);
    rd("mstatus_set", 12'h300, 32'h8);
    timer_irq = 1; pc_in = 32'h40; instr_valid = 1;
    tick();
    instr_valid = 0;
    chk("t1_trap_taken", {31'b0, trap_taken}, 1);
    chk("t1_trap_pc", trap_pc, 32'h100);
    tick();
    chk("t1_pulse_drop", {31'b0, trap_taken}, 0);
    rd("t1_mepc", 12'h341, 32'h40);
    rd("t1_mcause", 12'h342, 32'h8000_0007);
    rd("t1_mstatus", 12'h300, 32'h80);
    rd("mip_timer", 12'h344, 32'h80);
    do_mret(32'h40);
    rd("mret_mstatus", 12'h300, 32'h88);
    timer_irq = 0;
    csr(1, 12'h305, 32'h201);
    rd("mtvec_vec", 12'h305, 32'h201);
    csr(1, 12'h305, 32'h302);
    rd("mtvec_bad_mode", 12'h305, 32'h301);
    csr(1, 12'h305, 32'h201);
    csr(1, 12'h304, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'h000F_0088);
    csr(1, 12'h123, 32'hDEAD);
    rd("unknown_addr", 12'h123, 0);
    csr(1, 12'h344, 32'hFFFF_FFFF);
    rd("mip_ro", 12'h344, 0);
    sw_irq = 1; timer_irq = 1; ext_irq = 4'b0010; pc_in = 32'h80; instr_valid = 1;
    rd("mip_all", 12'h344, 32'h0002_0088);
    tick();
    instr_valid = 0;
    chk("prio_sw_taken", {31'b0, trap_taken}, 1);
    chk("prio_sw_pc", trap_pc, 32'h20C);
    tick();
    rd("prio_sw_cause", 12'h342, 32'h8000_0003);
    do_mret(32'h80);
    sw_irq = 0; instr_valid = 1;
    tick();
    instr_valid = 0;
    chk("prio_tmr_taken", {31'b0, trap_taken}, 1);
    chk("prio_tmr_pc", trap_pc, 32'h21C);
    tick();
    rd("prio_tmr_cause", 12'h342, 32'h8000_0007);
    timer_irq = 0;
    csr(2, 12'h300, 32'h8);
    instr_valid = 1;
    tick();
    instr_valid = 0;
    chk("prio_ext1_pc", trap_pc, 32'h244);
    tick();
    timer_irq = 1;
    instr_valid = 1; is_mret = 1;
    tick();
    is_mret = 0;
    chk("race_epc_first", {31'b0, epc_taken}, 1);
    chk("race_no_trap", {31'b0, trap_taken}, 0);
    tick();
    chk("race_redirect_no_trap", {31'b0, trap_taken}, 0);
    tick();
    instr_valid = 0;
    chk("race_trap_later", {31'b0, trap_taken}, 1);
    chk("race_trap_pc", trap_pc, 32'h21C);
    tick();
    do_mret(32'h80);
    csr_op = 1; csr_addr = 12'h341; csr_wdata = 32'h1237; pc_in = 32'hC0; instr_valid = 1;
    tick();
    csr_op = 0; instr_valid = 0;
    chk("wr_race_trap", {31'b0, trap_taken}, 1);
    rd("wr_race_mepc", 12'h341, 32'hC0);
    rst = 1;
    #1;
    chk("rst_mid_trap", {31'b0, trap_taken}, 0);
    chk("rst_mid_trap_pc", trap_pc, 0);
    rd("rst_mid_mtvec", 12'h305, 32'h100);
    tick();
    rst = 0;
    csr(1, 12'h341, 32'h1237);
    rd("mepc_align", 12'h341, 32'h1234);
    instr_valid = 1;
    tick();
    chk("mie_off_no_trap", {31'b0, trap_taken}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
